// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational zx/nx/zy/ny/f/no ALU between
// two requesters. Grants are round-robin. The winning opcode and operands are
// captured and decoded into ALU control bits. The ALU result and its zero and
// negative flags are registered and returned with the requester id.
//
// Ports:
//   i_clk, i_rst_n               clock, async active-low reset
//   i_req_valid / o_req_ready    per-requester handshake (bit k = requester k)
//   i_req{0,1}_op/_x/_y          per-requester opcode and operands
//   o_alu_{zx,nx,zy,ny,f,no}     ALU control bits (from the capture registers)
//   o_alu_x / o_alu_y            ALU operands (from the capture registers)
//   i_alu_o                      ALU result
//   o_rsp_valid / i_rsp_ready    response handshake
//   o_rsp_id/_data/_zr/_ng       registered response payload
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [3:0]       i_req0_op,
  input  logic [WIDTH-1:0] i_req0_x,
  input  logic [WIDTH-1:0] i_req0_y,
  input  logic [3:0]       i_req1_op,
  input  logic [WIDTH-1:0] i_req1_x,
  input  logic [WIDTH-1:0] i_req1_y,
  output logic             o_alu_zx,
  output logic             o_alu_nx,
  output logic             o_alu_zy,
  output logic             o_alu_ny,
  output logic             o_alu_f,
  output logic             o_alu_no,
  output logic [WIDTH-1:0] o_alu_x,
  output logic [WIDTH-1:0] o_alu_y,
  input  logic [WIDTH-1:0] i_alu_o,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_zr,
  output logic             o_rsp_ng
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q;
  logic             ptr_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic             id_q, rsp_valid_q, zr_q, ng_q;
  logic [WIDTH-1:0] data_q;
  logic [5:0]       ctrl;

  // Grant selection: pointer requester first, then the other one. Only
  // offered in IDLE, so ready is never set in EXEC or RESP.
  logic [1:0]       grant_d;
  logic             gid_d;
  logic [3:0]       op_d;
  logic [WIDTH-1:0] x_d, y_d;

  always_comb begin
    grant_d = 2'b00;
    if (state_q == IDLE) begin
      if (i_req_valid[ptr_q])       grant_d[ptr_q]  = 1'b1;
      else if (i_req_valid[~ptr_q]) grant_d[~ptr_q] = 1'b1;
    end
  end

  assign gid_d       = grant_d[1];
  assign op_d        = gid_d ? i_req1_op : i_req0_op;
  assign x_d         = gid_d ? i_req1_x  : i_req0_x;
  assign y_d         = gid_d ? i_req1_y  : i_req0_y;
  assign o_req_ready = grant_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      op_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      data_q      <= '0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|grant_d) begin
          op_q    <= op_d;
          x_q     <= x_d;
          y_q     <= y_d;
          id_q    <= gid_d;
          // Pointer always flips to the loser, even if it was idle.
          ptr_q   <= ~gid_d;
          state_q <= EXEC;
        end
        EXEC: begin
          data_q      <= i_alu_o;
          zr_q        <= (i_alu_o == '0);
          ng_q        <= i_alu_o[WIDTH-1];
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: if (i_rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Opcode -> {zx, nx, zy, ny, f, no}
  always_comb begin
    case (op_q)
      4'd0:    ctrl = 6'b101010; // 0
      4'd1:    ctrl = 6'b111111; // 1
      4'd2:    ctrl = 6'b111010; // -1
      4'd3:    ctrl = 6'b001100; // x
      4'd4:    ctrl = 6'b110000; // y
      4'd5:    ctrl = 6'b001101; // !x
      4'd6:    ctrl = 6'b110001; // !y
      4'd7:    ctrl = 6'b001111; // -x
      4'd8:    ctrl = 6'b110011; // -y
      4'd9:    ctrl = 6'b011111; // x+1
      4'd10:   ctrl = 6'b110111; // y+1
      4'd11:   ctrl = 6'b001110; // x-1
      4'd12:   ctrl = 6'b110010; // y-1
      4'd13:   ctrl = 6'b000010; // x+y
      4'd14:   ctrl = 6'b010011; // x-y
      default: ctrl = 6'b000000; // x&y
    endcase
  end

  assign {o_alu_zx, o_alu_nx, o_alu_zy, o_alu_ny, o_alu_f, o_alu_no} = ctrl;
  assign o_alu_x     = x_q;
  assign o_alu_y     = y_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = id_q;
  assign o_rsp_data  = data_q;
  assign o_rsp_zr    = zr_q;
  assign o_rsp_ng    = ng_q;

endmodule
